xadc_drp_multichannel_sampler: RTL and testbench
================================================

Name: xadc_drp_multichannel_sampler

Overview:
- Generalised successor to the two-channel XADC DRP stream adapter.
- On each XADC end-of-sequence, reads NUM_CHANNELS configured DRP result registers back to back.
- Optionally averages over 2^AVG_LOG2 sequences, then emits one packed AXIS beat per result for the COBS packetizer.
- Sits between the xadc_teachee IP and cobs_axis_adapter_wrapper, in the sys_clk domain.

Parameters:
- NUM_CHANNELS, 2, channels read per sequence (1..8).
- CHANNEL_ADDRS, {7'h1C, 7'h14}, packed NUM_CHANNELS*7-bit DRP addresses; channel 0 in the LSBs (default vaux4, vaux12).
- AVG_LOG2, 0, log2 of sequences averaged per output (0..4).
- DRP_TIMEOUT, 255, max cycles to wait for drdy.

Ports:
- xadc_dclk  in  1  sole clock.
- xadc_reset_n  in  1  asynchronous, active-low reset.
- xadc_eos  in  1  end-of-sequence pulse from XADC.
- xadc_daddr  out  7  DRP address.
- xadc_den  out  1  DRP enable, one-cycle pulse.
- xadc_drdy  in  1  DRP read data valid.
- xadc_do  in  16  DRP read data.
- sample_tdata  out  NUM_CHANNELS*16 (+8 with tag)  packed samples, channel 0 in LSBs.
- sample_tvalid  out  1  AXIS valid.
- sample_tready  in  1  AXIS ready.
- overflow_count  out  16  saturating count of dropped results.
- drp_timeout  out  1  one-cycle pulse on DRP timeout.

Behaviour:
- Reset: asynchronous, active-low.
  - Async assert clears state to IDLE and zeroes den, daddr, tvalid, tdata, overflow_count, drp_timeout, accumulators and counters.
  - Mid-transaction reset abandons the read; den drops immediately.
- FSM states: IDLE, REQ, WAIT, ACC, EMIT.
  - IDLE: on xadc_eos, idx<=0, go REQ. xadc_eos in any other state is ignored.
  - REQ: den=1 for exactly one cycle, daddr=CHANNEL_ADDRS[idx*7+:7], go WAIT. daddr holds until the next REQ.
  - WAIT: on drdy, add xadc_do to acc[idx]. acc is 16+AVG_LOG2 bits wide and cannot overflow.
    - If idx<NUM_CHANNELS-1: idx++, go REQ.
    - Otherwise: go ACC.
    - If DRP_TIMEOUT cycles elapse without drdy: pulse drp_timeout, clear the partial accumulation of the current sequence (restore pre-sequence sums), go IDLE.
  - ACC: seq_cnt++.
    - If seq_cnt wraps to 0 (2^AVG_LOG2 sequences done): go EMIT.
    - Otherwise: go IDLE.
  - EMIT: result[ch] = acc[ch] >> AVG_LOG2, truncated to 16 bits. Clear all acc, go IDLE.
    - If output register empty or (tvalid && tready) this cycle: load tdata, tvalid=1.
    - Otherwise: drop the result; overflow_count++ (saturates at 16'hFFFF).
- Output handshake: standard AXIS.
  - tdata stable while tvalid && !tready.
  - tvalid clears on the handshake cycle unless reloaded the same cycle.
- Latency: for AVG_LOG2=0 and single-cycle drdy, EOS to tvalid = 2*NUM_CHANNELS+3 cycles.
- AVG_LOG2=0: averaging degenerates to pass-through; every sequence emits.

Optional Feature:
- Macro: XADC_SEQ_TAG_EN.
- Defined:
  - tdata widens by 8 bits.
  - tdata[MSB-:8] carries an 8-bit emitted-result counter: reset 0, increments on each loaded result, wraps 255->0. Dropped results do not increment it.
  - Lets the host detect drops.
- Undefined: tdata is exactly NUM_CHANNELS*16 bits; no tag logic.

Test Plan:
- NUM_CHANNELS=2, AVG_LOG2=0, tready=1, eos, drdy 1 cycle after each den with do=16'h1230 then 16'h4560 -> den pulses with daddr 0x14 then 0x1C; tdata=32'h4560_1230, tvalid for one cycle.
- AVG_LOG2=2, channel-0 do values 16'h0010, 16'h0020, 16'h0030, 16'h0040 over 4 sequences -> exactly one beat after the 4th sequence, channel 0 = 16'h0028.
- tready=0, three sequences -> first result held stable, overflow_count=2; then tready=1 -> one handshake, tvalid low.
- drdy withheld -> drp_timeout pulses after 255 cycles, FSM back in IDLE; next eos completes normally with correct data.
- Assert xadc_reset_n=0 during WAIT -> den, tvalid, overflow_count go 0 immediately; after release, no output until next eos.
- XADC_SEQ_TAG_EN defined, 257 accepted results -> tags 0..255, then 0.

Source files
------------

// File: rtl/xadc_drp_multichannel_sampler.sv
// ---------------------------------------------------------------------------
// xadc_drp_multichannel_sampler
//
// Purpose:
//   On every XADC end-of-sequence pulse, reads NUM_CHANNELS DRP result
//   registers one after another. Results are averaged over 2^AVG_LOG2
//   sequences, and each average is emitted as one packed AXI-Stream beat
//   for the downstream COBS packetizer. Single clock domain (xadc_dclk).
//
// Optional feature (macro XADC_SEQ_TAG_EN):
//   When defined, sample_tdata is 8 bits wider. The top byte carries a
//   counter of emitted (loaded) results. It starts at 0, increments per
//   loaded beat and wraps 255->0. Dropped results do not advance it.
//
// Ports:
//   xadc_dclk       in   clock
//   xadc_reset_n    in   asynchronous active-low reset
//   xadc_eos        in   end-of-sequence pulse (ignored unless idle)
//   xadc_daddr      out  DRP address, held until the next request
//   xadc_den        out  DRP enable, one-cycle pulse per read
//   xadc_drdy       in   DRP read data valid
//   xadc_do         in   DRP read data
//   sample_tdata    out  packed averages, channel 0 in the LSBs (+tag byte)
//   sample_tvalid   out  AXIS valid
//   sample_tready   in   AXIS ready
//   overflow_count  out  saturating count of results dropped while full
//   drp_timeout     out  one-cycle pulse when a DRP read gets no drdy
// ---------------------------------------------------------------------------
module xadc_drp_multichannel_sampler #(
  parameter int                          NUM_CHANNELS  = 2,
  parameter logic [NUM_CHANNELS*7-1:0]   CHANNEL_ADDRS = {7'h1C, 7'h14},
  parameter int                          AVG_LOG2      = 0,
  parameter int                          DRP_TIMEOUT   = 255
) (
  input  logic                           xadc_dclk,
  input  logic                           xadc_reset_n,
  input  logic                           xadc_eos,
  output logic [6:0]                     xadc_daddr,
  output logic                           xadc_den,
  input  logic                           xadc_drdy,
  input  logic [15:0]                    xadc_do,
`ifdef XADC_SEQ_TAG_EN
  output logic [NUM_CHANNELS*16+7:0]     sample_tdata,
`else
  output logic [NUM_CHANNELS*16-1:0]     sample_tdata,
`endif
  output logic                           sample_tvalid,
  input  logic                           sample_tready,
  output logic [15:0]                    overflow_count,
  output logic                           drp_timeout
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SEQ_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TMO_W = $clog2(DRP_TIMEOUT + 1);
  localparam int RES_W = NUM_CHANNELS * 16;
`ifdef XADC_SEQ_TAG_EN
  localparam int TD_W  = RES_W + 8;
`else
  localparam int TD_W  = RES_W;
`endif

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACC,
    S_EMIT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [6:0]         daddr_q, daddr_d;
  logic               den_q, den_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               drp_timeout_q, drp_timeout_d;
  logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
  logic               tvalid_q, tvalid_d;
  logic [TD_W-1:0]    tdata_q, tdata_d;
  logic [15:0]        ovf_q, ovf_d;
`ifdef XADC_SEQ_TAG_EN
  logic [7:0]         tag_q, tag_d;
`endif

  // Per-channel datapath controls.
  logic               capture;
  logic               commit;
  logic               clear;
  logic [RES_W-1:0]   result_vec;

  function automatic logic [6:0] chan_addr(input logic [IDX_W-1:0] i);
    return CHANNEL_ADDRS[int'(i)*7 +: 7];
  endfunction

  // Each channel's reading for the current sequence is parked in cur_q and
  // only folded into acc_q once the whole sequence has completed. A DRP
  // timeout therefore leaves acc_q at its pre-sequence sums automatically.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    logic [15:0]      cur_q, cur_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
      cur_d = cur_q;
      if (capture && (idx_q == IDX_W'(gi))) begin
        cur_d = xadc_do;
      end
      acc_d = acc_q;
      if (commit) begin
        acc_d = acc_q + ACC_W'(cur_q);
      end else if (clear) begin
        acc_d = '0;
      end
    end

    always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
      if (!xadc_reset_n) begin
        cur_q <= '0;
        acc_q <= '0;
      end else begin
        cur_q <= cur_d;
        acc_q <= acc_d;
      end
    end

    assign result_vec[gi*16 +: 16] = 16'(acc_q >> AVG_LOG2);
  end

  assign commit = (state_q == S_ACC);
  assign clear  = (state_q == S_EMIT);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    daddr_d       = daddr_q;
    den_d         = 1'b0;
    tmo_cnt_d     = tmo_cnt_q;
    drp_timeout_d = 1'b0;
    seq_cnt_d     = seq_cnt_q;
    tdata_d       = tdata_q;
    ovf_d         = ovf_q;
    capture       = 1'b0;
    // Output register drains on a handshake unless reloaded below.
    tvalid_d      = tvalid_q && !sample_tready;
`ifdef XADC_SEQ_TAG_EN
    tag_d         = tag_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (xadc_eos) begin
          idx_d   = '0;
          daddr_d = chan_addr('0);
          den_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      // den/daddr are registered, so they were set on entry to REQ.
      S_REQ: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (xadc_drdy) begin
          capture = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_ACC;
          end else begin
            idx_d   = idx_q + 1'b1;
            daddr_d = chan_addr(idx_q + 1'b1);
            den_d   = 1'b1;
            state_d = S_REQ;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          drp_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_ACC: begin
        if (seq_cnt_q == SEQ_LAST) begin
          seq_cnt_d = '0;
          state_d   = S_EMIT;
        end else begin
          seq_cnt_d = seq_cnt_q + 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_EMIT: begin
        if (!tvalid_q || sample_tready) begin
          tvalid_d = 1'b1;
`ifdef XADC_SEQ_TAG_EN
          tdata_d  = {tag_q, result_vec};
          tag_d    = tag_q + 8'd1;
`else
          tdata_d  = result_vec;
`endif
        end else if (ovf_q != 16'hFFFF) begin
          ovf_d = ovf_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
    if (!xadc_reset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      daddr_q       <= '0;
      den_q         <= 1'b0;
      tmo_cnt_q     <= '0;
      drp_timeout_q <= 1'b0;
      seq_cnt_q     <= '0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      ovf_q         <= '0;
`ifdef XADC_SEQ_TAG_EN
      tag_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      daddr_q       <= daddr_d;
      den_q         <= den_d;
      tmo_cnt_q     <= tmo_cnt_d;
      drp_timeout_q <= drp_timeout_d;
      seq_cnt_q     <= seq_cnt_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      ovf_q         <= ovf_d;
`ifdef XADC_SEQ_TAG_EN
      tag_q         <= tag_d;
`endif
    end
  end

  assign xadc_daddr     = daddr_q;
  assign xadc_den       = den_q;
  assign sample_tdata   = tdata_q;
  assign sample_tvalid  = tvalid_q;
  assign overflow_count = ovf_q;
  assign drp_timeout    = drp_timeout_q;

endmodule

// File: tb/tb_xadc_drp_multichannel_sampler.sv
// ---------------------------------------------------------------------------
// tb_xadc_drp_multichannel_sampler
//
// Two instances share all inputs: u_dut (no averaging) and u_avg (average
// of 4 sequences). The bench acts as the DRP slave, keeps a sequence-level
// model of expected beats per instance, and a compare process checks every
// valid output beat against the model's queue head.
// ---------------------------------------------------------------------------
module tb_xadc_drp_multichannel_sampler;

  localparam int NCH = 2;
  localparam int TMO = 255;
`ifdef XADC_SEQ_TAG_EN
  localparam int TAGW = 8;
`else
  localparam int TAGW = 0;
`endif
  localparam int TW = NCH * 16 + TAGW;
  localparam logic [6:0] EXP_ADDR [NCH] = '{7'h14, 7'h1C};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, eos, drdy, tready;
  logic [15:0]   do_v;
  logic [6:0]    daddr0, daddr1;
  logic          den0, den1, tv0, tv1, tmo0, tmo1;
  logic [TW-1:0] td0, td1;
  logic [15:0]   ovf0, ovf1;

  xadc_drp_multichannel_sampler #(
    .NUM_CHANNELS(NCH), .CHANNEL_ADDRS({7'h1C, 7'h14}), .AVG_LOG2(0), .DRP_TIMEOUT(TMO)
  ) u_dut (
    .xadc_dclk(clk), .xadc_reset_n(rst_n), .xadc_eos(eos),
    .xadc_daddr(daddr0), .xadc_den(den0), .xadc_drdy(drdy), .xadc_do(do_v),
    .sample_tdata(td0), .sample_tvalid(tv0), .sample_tready(tready),
    .overflow_count(ovf0), .drp_timeout(tmo0)
  );

  xadc_drp_multichannel_sampler #(
    .NUM_CHANNELS(NCH), .CHANNEL_ADDRS({7'h1C, 7'h14}), .AVG_LOG2(2), .DRP_TIMEOUT(TMO)
  ) u_avg (
    .xadc_dclk(clk), .xadc_reset_n(rst_n), .xadc_eos(eos),
    .xadc_daddr(daddr1), .xadc_den(den1), .xadc_drdy(drdy), .xadc_do(do_v),
    .sample_tdata(td1), .sample_tvalid(tv1), .sample_tready(tready),
    .overflow_count(ovf1), .drp_timeout(tmo1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eos_cyc = 0;
  bit checking = 1'b0;

  // Sequence-level model state, index 0 = u_dut, 1 = u_avg.
  logic [TW-1:0] expq0[$];
  logic [TW-1:0] expq1[$];
  int unsigned   sum_m [2][NCH];
  int            cnt_m [2];
  logic [15:0]   ovf_m [2];
  logic [7:0]    tag_m [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    expq0.delete();
    expq1.delete();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) sum_m[m][c] = 0;
      cnt_m[m] = 0;
      ovf_m[m] = 16'd0;
      tag_m[m] = 8'd0;
    end
  endtask

  // One completed DRP sequence: accumulate, and when the averaging window
  // is full produce a result which is either queued or counted as dropped.
  task automatic model_seq(input logic [15:0] v0, input logic [15:0] v1);
    int            sh;
    int            qs;
    logic [TW-1:0] beat;
    for (int m = 0; m < 2; m++) begin
      sh = (m == 0) ? 0 : 2;
      sum_m[m][0] += v0;
      sum_m[m][1] += v1;
      cnt_m[m]++;
      if (cnt_m[m] == (1 << sh)) begin
        beat = '0;
        beat[15:0]  = 16'(sum_m[m][0] / (1 << sh));
        beat[31:16] = 16'(sum_m[m][1] / (1 << sh));
`ifdef XADC_SEQ_TAG_EN
        beat[TW-1 -: 8] = tag_m[m];
`endif
        sum_m[m][0] = 0;
        sum_m[m][1] = 0;
        cnt_m[m] = 0;
        qs = (m == 0) ? expq0.size() : expq1.size();
        if (qs != 0 && !tready) begin
          if (ovf_m[m] != 16'hFFFF) ovf_m[m] = ovf_m[m] + 16'd1;
        end else begin
          if (m == 0) expq0.push_back(beat);
          else        expq1.push_back(beat);
          tag_m[m] = tag_m[m] + 8'd1;
        end
      end
    end
  endtask

  // Compare process: every valid beat must match the model's queue head.
  always @(negedge clk) begin
    if (checking) begin
      if (tv0) begin
        if (expq0.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat0_unexpected: tdata=%h with no expected beat", td0);
        end else begin
          chk("beat0_data", 64'(td0), 64'(expq0[0]));
          if (tready) begin
            $display("beat dut=avg1 tdata=%h", td0);
            void'(expq0.pop_front());
          end
        end
      end
      if (tv1) begin
        if (expq1.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat1_unexpected: tdata=%h with no expected beat", td1);
        end else begin
          chk("beat1_data", 64'(td1), 64'(expq1[0]));
          if (tready) begin
            $display("beat dut=avg4 tdata=%h", td1);
            void'(expq1.pop_front());
          end
        end
      end
    end
  end

  // Drive one EOS and serve the DRP reads. Channels >= nresp get no drdy;
  // the task then returns at the negedge where that channel's den is seen.
  task automatic do_seq(input logic [15:0] v0, input logic [15:0] v1, input int nresp);
    int n;
    @(posedge clk); #2; eos = 1'b1; eos_cyc = cyc;
    @(posedge clk); #2; eos = 1'b0;
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) begin
      n = 0;
      while (!den0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (!den0) begin
        checks++; errors++;
        $display("FAIL den_wait: got no den for channel %0d expected den within 40 cycles", ch);
        return;
      end
      chk("daddr", 64'(daddr0), 64'(EXP_ADDR[ch]));
      chk("daddr_avg", 64'(daddr1), 64'(EXP_ADDR[ch]));
      if (ch >= nresp) return;
      @(negedge clk);
      chk("den_one_cycle", 64'(den0), 64'd0);
      drdy = 1'b1;
      do_v = (ch == 0) ? v0 : v1;
      @(negedge clk);
      drdy = 1'b0;
    end
    model_seq(v0, v1);
  endtask

  task automatic wait_tv(input int which);
    int n = 0;
    while (((which == 0) ? !tv0 : !tv1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if ((which == 0) ? !tv0 : !tv1) begin
      checks++; errors++;
      $display("FAIL tvalid_wait: got no tvalid on instance %0d expected within 20 cycles", which);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam logic [15:0] AV0 [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
  localparam logic [15:0] AV1 [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0401};

  initial begin
    int n;
    logic [7:0] tag;
    rst_n = 1'b1; eos = 1'b0; drdy = 1'b0; do_v = 16'h0; tready = 1'b1;
    model_clear();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_den", 64'(den0), 64'd0);
    chk("rst_daddr", 64'(daddr0), 64'd0);
    chk("rst_tvalid", 64'(tv0), 64'd0);
    chk("rst_tdata", 64'(td0), 64'd0);
    chk("rst_ovf", 64'(ovf0), 64'd0);
    chk("rst_tmo", 64'(tmo0), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    checking = 1'b1;

    // Averaging over 4 sequences: only the 4th produces a u_avg beat.
    for (int i = 0; i < 4; i++) begin
      do_seq(AV0[i], AV1[i], NCH);
      if (i == 3) begin
        wait_tv(1);
        chk("avg_ch0", 64'(td1[15:0]), 64'h0028);
        chk("avg_ch1", 64'(td1[31:16]), 64'h0280);
      end
      settle(6);
    end

    // Basic pass-through with latency check.
    do_seq(16'h1230, 16'h4560, NCH);
    wait_tv(0);
    chk("latency", 64'(cyc - eos_cyc), 64'd7);
    chk("basic_data", 64'(td0[31:0]), 64'h4560_1230);
    @(negedge clk);
    chk("basic_one_beat", 64'(tv0), 64'd0);
    settle(4);

    // Timeout on channel 1 after channel 0 answered; its data is discarded.
    do_seq(16'h7777, 16'h0000, 1);
    n = 0;
    while (!tmo0 && n < TMO + 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'(TMO + 1));
    chk("tmo_avg", 64'(tmo1), 64'd1);
    @(negedge clk);
    chk("tmo_pulse_width", 64'(tmo0), 64'd0);
    chk("tmo_den_idle", 64'(den0), 64'd0);
    do_seq(16'hABCD, 16'h0123, NCH);
    wait_tv(0);
    chk("after_tmo_data", 64'(td0[31:0]), 64'h0123_ABCD);
    settle(4);

    // Backpressure: first result held, next two dropped.
    @(posedge clk); #2 tready = 1'b0;
    do_seq(16'h0001, 16'h0002, NCH); settle(4);
    do_seq(16'h0003, 16'h0004, NCH); settle(4);
    do_seq(16'h0005, 16'h0006, NCH); settle(4);
    chk("bp_tvalid", 64'(tv0), 64'd1);
    chk("bp_held_data", 64'(td0[31:0]), 64'h0002_0001);
    chk("bp_ovf", 64'(ovf0), 64'd2);
    chk("bp_ovf_model", 64'(ovf0), 64'(ovf_m[0]));
    chk("bp_avg_data", 64'(td1[31:0]), 64'h11A2_2F80);
    chk("bp_avg_ovf", 64'(ovf1), 64'd0);
    @(posedge clk); #2 tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_drained", 64'(tv0), 64'd0);
    chk("bp_avg_drained", 64'(tv1), 64'd0);

    // Reset in the middle of a DRP read with a beat held and drops counted.
    @(posedge clk); #2 tready = 1'b0;
    do_seq(16'h0BAD, 16'h0CAB, NCH);
    settle(4);
    do_seq(16'h0000, 16'h0000, 0);
    @(negedge clk);
    chk("pre_rst_tvalid", 64'(tv0), 64'd1);
    chk("pre_rst_ovf", 64'(ovf0), 64'd2);
    #1;
    checking = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_den", 64'(den0), 64'd0);
    chk("mid_rst_tvalid", 64'(tv0), 64'd0);
    chk("mid_rst_ovf", 64'(ovf0), 64'd0);
    chk("mid_rst_tdata", 64'(td0), 64'd0);
    chk("mid_rst_avg_tvalid", 64'(tv1), 64'd0);
    model_clear();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1; tready = 1'b1;
    checking = 1'b1;
    settle(20);
    chk("post_rst_tvalid", 64'(tv0), 64'd0);
    chk("post_rst_den", 64'(den0), 64'd0);

`ifdef XADC_SEQ_TAG_EN
    // 257 loaded results: tags 0..255 then wrap to 0.
    for (int i = 0; i < 257; i++) begin
      do_seq(16'(i), 16'(i * 3), NCH);
      wait_tv(0);
      tag = td0[TW-1 -: 8];
      if (i == 0)   chk("tag_first", 64'(tag), 64'h00);
      if (i == 255) chk("tag_255", 64'(tag), 64'hFF);
      if (i == 256) chk("tag_wrap", 64'(tag), 64'h00);
      settle(2);
    end
`else
    tag = 8'h00;
`endif

    do_seq(16'h5555, 16'hAAAA, NCH);
    wait_tv(0);
    chk("final_data", 64'(td0[31:0]), 64'hAAAA_5555);
    settle(6);
    chk("q0_empty", 64'(expq0.size()), 64'd0);
    chk("q1_empty", 64'(expq1.size()), 64'd0);
    chk("final_ovf_model", 64'(ovf0), 64'(ovf_m[0]));
    chk("final_avg_ovf_model", 64'(ovf1), 64'(ovf_m[1]));
    if (tag === 8'hxx) $display("note tag unknown");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion expected finish before 600us");
    $fatal(1, "watchdog expired");
  end

endmodule
